i2s_frame_serializer: RTL

- Consumes stereo audio frames from the codec data FIFO and drives the I2S bus (bclk, wclk, data) to the Zybo audio CODEC.
- Sits directly downstream of the 48-bit audio FIFO in the codec unit.
- Generates bit and word clocks from its single clock.
- Reports FIFO underruns to the register unit.

---
 rtl/codec_unit_pkg.sv | 20 ++
 rtl/i2s_bclk_gen.sv | 50 +++++
 rtl/i2s_frame_serializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/codec_unit_pkg.sv
// Shared definitions for the codec unit's I2S path: slot/frame geometry, serializer states
// and the default-width stereo frame layout.
package codec_unit_pkg;

  localparam int unsigned I2S_SLOT_BITS  = 32;
  localparam int unsigned I2S_FRAME_BITS = 64;
  localparam int unsigned I2S_SAMPLE_W   = 24;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } i2s_state_t;

  // Left occupies the upper half of the FIFO word, right the lower half.
  typedef struct packed {
    logic [I2S_SAMPLE_W-1:0] left;
    logic [I2S_SAMPLE_W-1:0] right;
  } i2s_frame_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF clk cycles while running and flags the
// cycle before each rising/falling transition so downstream state can update on that edge.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic bclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [CNT_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             wrap;

  assign wrap = run && (div_q == CNT_W'(BCLK_HALF - 1));

  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!run) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d = div_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk     = bclk_q;
  assign rise_stb = wrap && !bclk_q;
  assign fall_stb = wrap && bclk_q;

endmodule

// File: rtl/i2s_frame_serializer.sv
// Streams 48-bit stereo FIFO words onto an I2S bus (one-bclk delayed, MSB first) and counts
// frames that start with the FIFO empty.
module i2s_frame_serializer
  import codec_unit_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = I2S_SAMPLE_W,
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [2*SAMPLE_W-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  output logic                  i2s_bclk,
  output logic                  i2s_wclk,
  output logic                  i2s_data,
  output logic                  busy,
  output logic                  underrun,
  output logic [15:0]           underrun_count,
  input  logic                  clear_underrun
);

  localparam int unsigned BIT_W = $clog2(I2S_FRAME_BITS);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  i2s_state_t       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  frame_t           frame_q, frame_d;
  logic             wclk_q, wclk_d;
  logic             data_q, data_d;
  logic             rd_q, rd_d;
  logic             under_q, under_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             rise_stb, fall_stb;
  logic [BIT_W-1:0] bit_nxt;
  int unsigned      pos;
  logic [SAMPLE_W-1:0] sample, shifted;
  logic             next_bit;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk      (clk),
    .resetn   (resetn),
    .run      (state_q == RUN),
    .bclk     (i2s_bclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Serial bit for the slot position reached on the coming falling edge.
  always_comb begin
    bit_nxt  = bit_cnt_q + BIT_W'(1);
    pos      = 32'(bit_nxt) % I2S_SLOT_BITS;
    sample   = bit_nxt[BIT_W-1] ? frame_q.right : frame_q.left;
    shifted  = '0;
    next_bit = 1'b0;
    if (pos >= 1 && pos <= SAMPLE_W) begin
      shifted  = sample << (pos - 1);
      next_bit = shifted[SAMPLE_W-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    wclk_d    = wclk_q;
    data_d    = data_q;
    rd_d      = 1'b0;
    under_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        wclk_d    = 1'b0;
        data_d    = 1'b0;
        if (enable) begin
          state_d   = RUN;
          bit_cnt_d = '1;
          wclk_d    = 1'b1;
        end
      end
      RUN: begin
        if (fall_stb) begin
          bit_cnt_d = bit_nxt;
          wclk_d    = bit_nxt[BIT_W-1];
          data_d    = next_bit;
          // Frame boundary: enable is only honoured here, so frames never truncate.
          if (bit_cnt_q == '1) begin
            if (!enable) begin
              state_d = IDLE;
            end else if (!fifo_empty) begin
              frame_d = frame_t'(fifo_data);
              rd_d    = 1'b1;
            end else begin
              frame_d = '0;
              under_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_underrun) begin
      cnt_d = {15'd0, under_q};
    end else if (under_q && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      wclk_q    <= 1'b0;
      data_q    <= 1'b0;
      rd_q      <= 1'b0;
      under_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      wclk_q    <= wclk_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      under_q   <= under_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fifo_rd        = rd_q;
  assign i2s_wclk       = wclk_q;
  assign i2s_data       = data_q;
  assign busy           = (state_q == RUN);
  assign underrun       = under_q;
  assign underrun_count = cnt_q;

  // Divider strobes are mutually exclusive by construction.
  assert property (@(posedge clk) disable iff (!resetn) !(rise_stb && fall_stb));

endmodule
